// File: rtl/ifetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_queue_unit
//  Description : Parametrised instruction fetcher. Issues one request at a
//                time to the icache, buffers returned words in a FIFO, applies
//                static next-PC prediction and hands {ins, pc, pred} to the
//                decoder through a valid/ready handshake. A flush from the
//                ROB/branch unit redirects fetch and empties the FIFO.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN         width of instruction, PC and predicted target
//    QUEUE_DEPTH  FIFO entries (power of two, >= 2)
//    RESET_PC     first fetch address after reset
//    PRED_MODE    0 = always not-taken, 1 = JAL taken + BTFN for B-type
//  Ports
//    clk_in             in   system clock
//    rst_in             in   asynchronous reset, active low
//    rdy_in             in   global ready; low freezes every register
//    input_ins          in   instruction word returned by the icache
//    input_ins_ready    in   one-cycle pulse, input_ins valid for request
//    pc                 out  fetch address to the icache
//    is_fetching        out  request valid to the icache
//    dec_ready_in       in   decoder accepts the head entry this cycle
//    output_ins         out  head instruction
//    output_ins_ready   out  head entry valid
//    output_pc          out  PC of the head instruction
//    output_pred_taken  out  head predicted taken
//    output_pred_pc     out  predicted next PC of the head
//    flush_in           in   redirect request, highest priority
//    flush_pc           in   redirect target
// ============================================================================
module ifetch_queue_unit #(
    parameter int              XLEN        = 32,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              PRED_MODE   = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic [XLEN-1:0] input_ins,
    input  logic            input_ins_ready,
    output logic [XLEN-1:0] pc,
    output logic            is_fetching,
    input  logic            dec_ready_in,
    output logic [XLEN-1:0] output_ins,
    output logic            output_ins_ready,
    output logic [XLEN-1:0] output_pc,
    output logic            output_pred_taken,
    output logic [XLEN-1:0] output_pred_pc,
    input  logic            flush_in,
    input  logic [XLEN-1:0] flush_pc
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_ptr_w     = $clog2(QUEUE_DEPTH);
    localparam int                  c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0]     c_ins_bytes = XLEN'(4);
    localparam logic [6:0]          c_op_jal    = 7'b1101111;
    localparam logic [6:0]          c_op_branch = 7'b1100011;

    // ------------------------------------------------------------------------
    // Fetch FSM encoding
    //   ST_IDLE    : no request; waits for a free FIFO slot
    //   ST_REQ     : request outstanding at r_pc, response is enqueued
    //   ST_DISCARD : request outstanding for a flushed path, response dropped
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_saved_pc;
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]   r_count;

    logic [XLEN-1:0]      r_q_ins   [QUEUE_DEPTH];
    logic [XLEN-1:0]      r_q_pc    [QUEUE_DEPTH];
    logic                 r_q_taken [QUEUE_DEPTH];
    logic [XLEN-1:0]      r_q_tgt   [QUEUE_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [XLEN-1:0]      w_pc_nxt;
    logic [XLEN-1:0]      w_saved_nxt;
    logic                 w_enq;
    logic                 w_pop;
    logic                 w_clear;
    logic                 w_valid;
    logic [c_cnt_w-1:0]   w_cnt_after;
    logic [XLEN-1:0]      w_seq_pc;
    logic                 w_pred_taken;
    logic [XLEN-1:0]      w_pred_pc;

    assign w_seq_pc = r_pc + c_ins_bytes;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && dec_ready_in;

    // Occupancy once the current response lands; the FSM only sits in ST_REQ
    // with a free slot, so this never exceeds c_depth.
    assign w_cnt_after = r_count + c_cnt_w'(1) - c_cnt_w'(w_pop);

    // ------------------------------------------------------------------------
    // Static prediction of the word being returned for r_pc
    // ------------------------------------------------------------------------
    generate
        if (PRED_MODE == 1) begin : g_pred_btfn
            logic [6:0]      w_opcode;
            logic [XLEN-1:0] w_j_imm;
            logic [XLEN-1:0] w_b_imm;

            assign w_opcode = input_ins[6:0];
            // Sign bit replication also covers imm[20] (J) and imm[12] (B).
            assign w_j_imm  = {{(XLEN-20){input_ins[31]}}, input_ins[19:12],
                               input_ins[20], input_ins[30:21], 1'b0};
            assign w_b_imm  = {{(XLEN-12){input_ins[31]}}, input_ins[7],
                               input_ins[30:25], input_ins[11:8], 1'b0};

            always_comb begin
                w_pred_taken = 1'b0;
                w_pred_pc    = w_seq_pc;
                if (w_opcode == c_op_jal) begin
                    w_pred_taken = 1'b1;
                    w_pred_pc    = r_pc + w_j_imm;
                end else if ((w_opcode == c_op_branch) && input_ins[31]) begin
                    // Backward branch (negative offset) predicted taken.
                    w_pred_taken = 1'b1;
                    w_pred_pc    = r_pc + w_b_imm;
                end
            end
        end else begin : g_pred_not_taken
            assign w_pred_taken = 1'b0;
            assign w_pred_pc    = w_seq_pc;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_saved_nxt = r_saved_pc;
        w_enq       = 1'b0;
        w_clear     = 1'b0;
        is_fetching = (r_state != ST_IDLE);

        if (flush_in) begin
            w_clear = 1'b1;
            if ((r_state == ST_IDLE) || input_ins_ready) begin
                // Nothing left in flight: restart immediately at the target.
                w_pc_nxt    = flush_pc;
                w_state_nxt = ST_REQ;
            end else begin
                // A response is still owed for the old path; let it drain
                // before fetching the target.
                w_saved_nxt = flush_pc;
                w_state_nxt = ST_DISCARD;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count < c_depth) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (input_ins_ready) begin
                        w_enq    = 1'b1;
                        w_pc_nxt = w_pred_pc;
                        if (w_cnt_after >= c_depth) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (input_ins_ready) begin
                        w_pc_nxt    = r_saved_pc;
                        w_state_nxt = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, PC and FIFO pointer registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_saved_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (rdy_in) begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_saved_pc <= w_saved_nxt;
            if (w_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_w'(1);
                end
                r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_pop);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage. Entries are only observable while counted as valid, so
    // the array itself carries no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_enq) begin
            r_q_ins[r_tail]   <= input_ins;
            r_q_pc[r_tail]    <= r_pc;
            r_q_taken[r_tail] <= w_pred_taken;
            r_q_tgt[r_tail]   <= w_pred_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Head fields are forced to zero while the FIFO is empty so the
    // decoder side reads all-zero after reset or a flush.
    // ------------------------------------------------------------------------
    assign pc                = r_pc;
    assign output_ins_ready  = w_valid;
    assign output_ins        = w_valid ? r_q_ins[r_head]   : '0;
    assign output_pc         = w_valid ? r_q_pc[r_head]    : '0;
    assign output_pred_taken = w_valid ? r_q_taken[r_head] : 1'b0;
    assign output_pred_pc    = w_valid ? r_q_tgt[r_head]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ifetch_queue_unit
//  Description : Self-checking bench for ifetch_queue_unit. Directed
//                sequences for streaming, back-pressure, prediction vectors,
//                flush corner cases and reset, followed by a randomized run
//                compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] ADDI  = 32'h00100093;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rdy;
    logic [XLEN-1:0] ins_in;
    logic            ins_rdy;
    logic            dec_rdy;
    logic            flush;
    logic [XLEN-1:0] flush_pc_s;

    logic [XLEN-1:0] f_pc, o_ins, o_pc, o_ppc;
    logic            fetching, o_vld, o_tk;
    logic [XLEN-1:0] nt_f_pc, nt_o_ins, nt_o_pc, nt_o_ppc;
    logic            nt_fetching, nt_o_vld, nt_o_tk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifetch_queue_unit #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .RESET_PC('0), .PRED_MODE(1)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .input_ins(ins_in), .input_ins_ready(ins_rdy),
        .pc(f_pc), .is_fetching(fetching), .dec_ready_in(dec_rdy),
        .output_ins(o_ins), .output_ins_ready(o_vld), .output_pc(o_pc),
        .output_pred_taken(o_tk), .output_pred_pc(o_ppc),
        .flush_in(flush), .flush_pc(flush_pc_s)
    );

    ifetch_queue_unit #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .RESET_PC('0), .PRED_MODE(0)) u_dut_nt (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .input_ins(ins_in), .input_ins_ready(ins_rdy),
        .pc(nt_f_pc), .is_fetching(nt_fetching), .dec_ready_in(dec_rdy),
        .output_ins(nt_o_ins), .output_ins_ready(nt_o_vld), .output_pc(nt_o_pc),
        .output_pred_taken(nt_o_tk), .output_pred_pc(nt_o_ppc),
        .flush_in(flush), .flush_pc(flush_pc_s)
    );

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs (called at a negedge) and return at the next negedge.
    task automatic step(input logic resp, input logic [31:0] ins, input logic drdy,
                        input logic fl, input logic [31:0] fpc);
        rdy        = 1'b1;
        ins_rdy    = resp;
        ins_in     = ins;
        dec_rdy    = drdy;
        flush      = fl;
        flush_pc_s = fpc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; ins_rdy = 1'b0; ins_in = '0;
        dec_rdy = 1'b0; flush = 1'b0; flush_pc_s = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},       f_pc,     32'h0);
        chk({tag, "_fetching"}, fetching, 32'h0);
        chk({tag, "_valid"},    o_vld,    32'h0);
        chk({tag, "_ins"},      o_ins,    32'h0);
        chk({tag, "_opc"},      o_pc,     32'h0);
        chk({tag, "_ppc"},      o_ppc,    32'h0);
        chk({tag, "_taken"},    o_tk,     32'h0);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: prediction from the instruction encoding rules
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } entry_t;

    function automatic entry_t predict(input logic [31:0] ins, input logic [31:0] pc);
        entry_t            e;
        logic signed [20:0] jimm;
        logic signed [12:0] bimm;
        jimm    = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bimm    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.ins   = ins;
        e.pc    = pc;
        e.taken = 1'b0;
        e.tgt   = pc + 32'd4;
        if (ins[6:0] == 7'b1101111) begin
            e.taken = 1'b1;
            e.tgt   = pc + 32'($signed(jimm));
        end else if (ins[6:0] == 7'b1100011 && bimm < 0) begin
            e.taken = 1'b1;
            e.tgt   = pc + 32'($signed(bimm));
        end
        return e;
    endfunction

    // Model state: queued entries, fetch address, whether a request is in
    // flight, whether that in-flight response belongs to a flushed path.
    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic        m_busy;
    logic        m_drop;
    logic [31:0] m_saved;

    task automatic model_reset();
        m_q.delete();
        m_pc = 32'h0; m_busy = 1'b0; m_drop = 1'b0; m_saved = 32'h0;
    endtask

    task automatic model_step(input logic r, input logic resp, input logic [31:0] ins,
                              input logic drdy, input logic fl, input logic [31:0] fpc);
        int     sz;
        logic   pop;
        entry_t e;
        if (!r) return;
        sz  = m_q.size();
        pop = (sz != 0) && drdy;
        if (fl) begin
            m_q.delete();
            if (!m_busy || resp) begin
                m_pc = fpc; m_busy = 1'b1; m_drop = 1'b0;
            end else begin
                m_saved = fpc; m_drop = 1'b1;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!m_busy) begin
                if (sz < DEPTH) m_busy = 1'b1;
            end else if (resp) begin
                if (m_drop) begin
                    m_pc = m_saved; m_drop = 1'b0;
                end else begin
                    e = predict(ins, m_pc);
                    m_q.push_back(e);
                    m_pc = e.tgt;
                    if (m_q.size() == DEPTH) m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_fetching", fetching, m_busy);
        chk("rnd_pc",       f_pc,     m_pc);
        chk("rnd_valid",    o_vld,    (m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("rnd_ins",   o_ins, m_q[0].ins);
            chk("rnd_opc",   o_pc,  m_q[0].pc);
            chk("rnd_taken", o_tk,  m_q[0].taken);
            chk("rnd_ppc",   o_ppc, m_q[0].tgt);
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       return {r[31:7], 7'b0010011};
            1:       return {r[31:7], 7'b1101111};
            2:       return {r[31:7], 7'b1100011};
            default: return {r[31:7], 7'b1100111};
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Prediction vectors
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int npop;
        int lat;
        logic prev_fetch, prev_resp;
        logic r_r, r_resp, r_drdy, r_fl;
        logic [31:0] r_ins, r_fpc;

        vecs[0] = '{32'hFE0008E3, 32'h0000_0100, 1'b1, 32'h0000_00F0}; // beq -16
        vecs[1] = '{32'h0200006F, 32'h0000_0040, 1'b1, 32'h0000_0060}; // jal +0x20
        vecs[2] = '{32'h00008067, 32'h0000_0040, 1'b0, 32'h0000_0044}; // jalr
        vecs[3] = '{32'h00100093, 32'h0000_0000, 1'b0, 32'h0000_0004}; // addi
        vecs[4] = '{32'h00000463, 32'h0000_0200, 1'b0, 32'h0000_0204}; // beq +8
        vecs[5] = '{32'hFFDFF06F, 32'h0000_1000, 1'b1, 32'h0000_0FFC}; // jal -4
        vecs[6] = '{32'hFE0008E3, 32'h0000_0004, 1'b1, 32'hFFFF_FFF4}; // wraps

        // ---- reset values and single-cycle streaming -------------------------
        do_reset();
        chk_reset_outputs("reset");
        step(1'b0, ADDI, 1'b1, 1'b0, 32'h0);
        chk("stream_first_req", fetching, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, ADDI, 1'b1, 1'b0, 32'h0);
            chk($sformatf("stream_valid%0d", k), o_vld, 32'h1);
            chk($sformatf("stream_opc%0d", k),   o_pc,  32'(4 * k));
            chk($sformatf("stream_taken%0d", k), o_tk,  32'h0);
            chk($sformatf("stream_fpc%0d", k),   f_pc,  32'(4 * k + 4));
        end

        // ---- back-pressure fills the FIFO, then drains in order ---------------
        do_reset();
        for (int c = 0; c < 8; c++) step(fetching, ADDI, 1'b0, 1'b0, 32'h0);
        chk("full_fetching", fetching, 32'h0);
        chk("full_head",     o_pc,     32'h0);
        chk("full_next_pc",  f_pc,     32'h10);
        npop = 0;
        for (int c = 0; c < 20 && npop < 5; c++) begin
            if (o_vld) begin
                chk($sformatf("drain_pc%0d", npop), o_pc, 32'(npop * 4));
                npop++;
            end
            step(fetching, ADDI, 1'b1, 1'b0, 32'h0);
        end
        chk("drain_count", npop, 32'd5);

        // ---- prediction table (both PRED_MODE instances) ----------------------
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'h0, 1'b0, 1'b1, vecs[i].pc);
            step(1'b1, vecs[i].ins, 1'b0, 1'b0, 32'h0);
            chk($sformatf("vec%0d_valid", i),  o_vld,    32'h1);
            chk($sformatf("vec%0d_ins", i),    o_ins,    vecs[i].ins);
            chk($sformatf("vec%0d_opc", i),    o_pc,     vecs[i].pc);
            chk($sformatf("vec%0d_taken", i),  o_tk,     vecs[i].taken);
            chk($sformatf("vec%0d_ppc", i),    o_ppc,    vecs[i].tgt);
            chk($sformatf("vec%0d_fpc", i),    f_pc,     vecs[i].tgt);
            chk($sformatf("vec%0d_nt_taken", i), nt_o_tk,  32'h0);
            chk($sformatf("vec%0d_nt_ppc", i),   nt_o_ppc, vecs[i].pc + 32'd4);
            chk($sformatf("vec%0d_nt_fpc", i),   nt_f_pc,  vecs[i].pc + 32'd4);
        end

        // ---- flush with a request outstanding, response 3 cycles later --------
        do_reset();
        step(1'b0, ADDI, 1'b0, 1'b0, 32'h0);
        step(1'b0, ADDI, 1'b0, 1'b1, 32'h200);
        chk("disc_fetching", fetching, 32'h1);
        chk("disc_stale_pc", f_pc,     32'h0);
        chk("disc_valid",    o_vld,    32'h0);
        step(1'b0, ADDI, 1'b0, 1'b0, 32'h0);
        step(1'b0, ADDI, 1'b0, 1'b0, 32'h0);
        step(1'b1, ADDI, 1'b0, 1'b0, 32'h0);
        chk("disc_redirect_pc", f_pc,     32'h200);
        chk("disc_fetching2",   fetching, 32'h1);
        chk("disc_empty",       o_vld,    32'h0);
        step(1'b1, ADDI, 1'b0, 1'b0, 32'h0);
        chk("disc_first_valid", o_vld, 32'h1);
        chk("disc_first_pc",    o_pc,  32'h200);

        // ---- flush coincident with response and pop ---------------------------
        do_reset();
        step(1'b0, ADDI, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) step(1'b1, ADDI, 1'b0, 1'b0, 32'h0);
        step(1'b1, ADDI, 1'b1, 1'b1, 32'h300);
        chk("fl_resp_valid", o_vld,    32'h0);
        chk("fl_resp_pc",    f_pc,     32'h300);
        chk("fl_resp_fetch", fetching, 32'h1);
        for (int c = 0; c < 6; c++) step(fetching, ADDI, 1'b0, 1'b0, 32'h0);
        chk("fl_full_idle", fetching, 32'h0);
        step(1'b1, ADDI, 1'b1, 1'b1, 32'h380);
        chk("fl_full_valid", o_vld, 32'h0);
        chk("fl_full_pc",    f_pc,  32'h380);
        step(1'b1, ADDI, 1'b0, 1'b0, 32'h0);
        chk("fl_full_head", o_pc,  32'h380);
        chk("fl_full_one",  o_vld, 32'h1);

        // ---- asynchronous reset in the middle of a request --------------------
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, ADDI, 1'b0, 1'b0, 32'h0);
        chk("midrst_ignored", o_vld,    32'h0);
        chk("midrst_req",     fetching, 32'h1);
        chk("midrst_req_pc",  f_pc,     32'h0);
        step(1'b1, ADDI, 1'b0, 1'b0, 32'h0);
        chk("midrst_first",   o_vld,    32'h1);

        // ---- randomized run against the reference model -----------------------
        do_reset();
        model_reset();
        prev_fetch = 1'b0;
        prev_resp  = 1'b0;
        lat        = 0;
        for (int cyc = 0; cyc < 4000 && bad < 50; cyc++) begin
            model_check();
            r_r    = ($urandom_range(0, 9) != 0);
            r_drdy = ($urandom_range(0, 2) != 0);
            r_fl   = ($urandom_range(0, 24) == 0);
            r_fpc  = $urandom() & 32'hFFFF_FFFC;
            r_ins  = rand_ins();
            r_resp = 1'b0;
            if (r_r) begin
                // icache: a new request starts on a fetching cycle that
                // follows an idle cycle or a response
                if (m_busy && (!prev_fetch || prev_resp)) lat = $urandom_range(0, 3);
                if (m_busy) begin
                    if (lat == 0) r_resp = 1'b1;
                    else          lat--;
                end
                prev_fetch = m_busy;
                prev_resp  = r_resp;
            end
            rdy        = r_r;
            ins_rdy    = r_resp;
            ins_in     = r_ins;
            dec_rdy    = r_drdy;
            flush      = r_fl;
            flush_pc_s = r_fpc;
            model_step(r_r, r_resp, r_ins, r_drdy, r_fl, r_fpc);
            @(negedge clk);
        end
        model_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
